wakeup_dependency_matrix: RTL
=============================

// Module: wakeup_dependency_matrix
// PURPOSE
//  Issue-queue-side consumer of the wakeup/release stream from the scheduler wakeup pipeline.
//  Holds one dependency row per IQ entry: bit j of row i is set while entry i waits on producer entry j.
//  Clears columns on wakeup, frees entries on release/flush, and drives the per-entry ready vector to select logic.
//  Sits between dispatch (row write), select (issued marking) and the wakeup pipeline (column clear / release).
// PARAMETERS
//  NUM_ENTRIES     16  issue queue entries (N); IDXW = $clog2(N)
//  DISPATCH_WIDTH  2   ops written per cycle
//  WAKEUP_WIDTH    3   wakeup ports; also select ports and release ports (one per issue lane)
// PORTS
//  clk             in   1       clock
//  rst             in   1       asynchronous, active-low reset
//  dispatch        in   DW      per-lane dispatch valid
//  dispatchPtr     in   DW*IDXW target entry per lane
//  dispatchDep     in   DW*N    producer vector (OR of source producers' one-hots)
//  wakeup          in   WW      per-lane wakeup valid
//  wakeupVector    in   WW*N    one-hot producer entry being woken
//  selected        in   WW      per-lane select grant
//  selectedPtr     in   WW*IDXW granted entry
//  releaseEntry    in   WW      per-lane release valid
//  releasePtr      in   WW*IDXW entry to free
//  flushEntry      in   N       entries to invalidate this cycle
//  readyVector     out  N       valid & !issued & row==0
//  validVector     out  N       occupied entries
//  entryCount      out  IDXW+1  popcount(validVector)
//  protocolError   out  1       sticky error flag
// BEHAVIOUR
//  - State per entry: valid, issued, depRow[N]. All outputs come from state (registered); reset (rst=0, async):
//    all valid/issued/depRow=0, readyVector=0, validVector=0, entryCount=0, protocolError=0.
//  - Wake mask W = OR over lanes k with wakeup[k] of wakeupVector[k]. Every cycle: depRow[i] <= depRow[i] & ~W.
//    Wakeup is idempotent (a repeated wakeup during stall clears nothing new).
//  - Dispatch lane d: valid<=1, issued<=0, depRow<=dispatchDep[d] & ~W (same-cycle wakeup bypassed into the write).
//    Self bit (dispatchDep bit == dispatchPtr) is ignored/cleared.
//  - Select lane k: issued[selectedPtr]<=1; entry leaves readyVector next cycle; depRow untouched.
//  - Release lane k: valid<=0, issued<=0, depRow<=0. Release of an invalid entry: no state change.
//  - Flush: flushEntry[i] clears valid/issued/depRow of i. Column i is NOT cleared in other rows
//    (flushed producers' consumers are younger and also flushed).
//  - Priority on the same entry in one cycle: dispatch > flush > release > select.
//  - Errors (protocolError set, stays set until reset): dispatch to a valid entry not released/flushed this cycle
//    (write still applied); two dispatch lanes to the same ptr (lower lane wins); select of an entry not in readyVector.
//  - entryCount reflects next-state occupancy one cycle after the update; never exceeds N (N entries full is legal).
//  - Select-to-ready latency: dispatched op with dep=0 appears in readyVector the cycle after dispatch.
//    Woken op appears the cycle after the wakeup cycle.
//  - No internal stall input: stall is handled upstream (held wakeup, gated release).
// CONFIGURATION
//  RSD_WAKEUP_READY_BYPASS_EN defined: readyVector additionally includes valid & !issued entries whose
//    (depRow & ~W)==0 in the current cycle; a woken consumer is selectable in the same cycle as the wakeup.
//    readyVector then becomes partially combinational from wakeup/wakeupVector.
//  Undefined: readyVector is purely registered as above (one extra cycle wakeup-to-ready).
// TESTING
//  1 Reset: hold rst=0 with random inputs -> all outputs 0; release rst -> still 0 until a dispatch.
//  2 Dispatch ptr 3, dep=0 -> readyVector=16'h0008 next cycle, entryCount=1; select 3 -> bit 3 clears next cycle.
//  3 Dispatch 5 dep=bit2|bit7; wakeup vec bit2 -> not ready; wakeup vec bit7 -> readyVector[5]=1 next cycle
//    (with _EN: same cycle as the bit7 wakeup).
//  4 Dispatch 6 dep=bit4 in the same cycle as wakeup bit4 -> readyVector[6]=1 next cycle (bypass into the write).
//  5 Fill all 16 entries -> entryCount=16; flushEntry=16'hFF00 plus release ptr 0 -> entryCount=7.
//    Dispatch to ptr 9 in the same cycle as flushEntry bit9 -> entry 9 valid, protocolError stays 0.
//  6 Dispatch to occupied ptr 2 -> protocolError=1 and stays set; select of non-ready ptr also sets it.

Source files
------------

// File: rtl/wakeup_dependency_matrix.sv
// ---------------------------------------------------------------------------
// wakeup_dependency_matrix
//
// Purpose
//   Issue-queue dependency matrix. Row i holds the set of producer entries
//   that IQ entry i still waits on (bit j set = waits on entry j). Each cycle
//   the matrix:
//     - clears woken producer columns,
//     - writes rows for newly dispatched ops,
//     - marks selected entries as issued,
//     - frees entries on release or flush.
//   It drives the per-entry ready vector to the select logic.
//
// Optional feature (macro RSD_WAKEUP_READY_BYPASS_EN)
//   When defined, readyVector also includes entries whose last outstanding
//   producers are being woken this cycle. A woken consumer is then selectable
//   in the wakeup cycle, and readyVector is partly combinational from
//   wakeup/wakeupVector.
//   When undefined, readyVector is derived from registered state only.
//
// Ports
//   clk            clock
//   rst            asynchronous reset, active low
//   dispatch       per-lane dispatch valid              [DISPATCH_WIDTH]
//   dispatchPtr    per-lane target entry                [DISPATCH_WIDTH*IDXW]
//   dispatchDep    per-lane producer vector             [DISPATCH_WIDTH*N]
//   wakeup         per-lane wakeup valid                [WAKEUP_WIDTH]
//   wakeupVector   per-lane one-hot woken producer      [WAKEUP_WIDTH*N]
//   selected       per-lane select grant                [WAKEUP_WIDTH]
//   selectedPtr    per-lane granted entry               [WAKEUP_WIDTH*IDXW]
//   releaseEntry   per-lane release valid               [WAKEUP_WIDTH]
//   releasePtr     per-lane entry to free               [WAKEUP_WIDTH*IDXW]
//   flushEntry     entries to invalidate this cycle     [N]
//   readyVector    valid & !issued & no pending deps    [N]
//   validVector    occupied entries                     [N]
//   entryCount     number of occupied entries           [IDXW+1]
//   protocolError  sticky protocol-violation flag
//
// Handshake
//   Every input group is a single-cycle strobe qualified by its own valid bit
//   (dispatch / wakeup / selected / releaseEntry / flushEntry bits). There is
//   no backpressure: a strobe is consumed in the cycle it is presented, and
//   upstream logic is responsible for holding or gating it during stalls.
// ---------------------------------------------------------------------------
module wakeup_dependency_matrix #(
  parameter int NUM_ENTRIES    = 16,
  parameter int DISPATCH_WIDTH = 2,
  parameter int WAKEUP_WIDTH   = 3,
  localparam int N             = NUM_ENTRIES,
  localparam int IDXW          = $clog2(NUM_ENTRIES)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [DISPATCH_WIDTH-1:0]      dispatch,
  input  logic [DISPATCH_WIDTH*IDXW-1:0] dispatchPtr,
  input  logic [DISPATCH_WIDTH*N-1:0]    dispatchDep,
  input  logic [WAKEUP_WIDTH-1:0]        wakeup,
  input  logic [WAKEUP_WIDTH*N-1:0]      wakeupVector,
  input  logic [WAKEUP_WIDTH-1:0]        selected,
  input  logic [WAKEUP_WIDTH*IDXW-1:0]   selectedPtr,
  input  logic [WAKEUP_WIDTH-1:0]        releaseEntry,
  input  logic [WAKEUP_WIDTH*IDXW-1:0]   releasePtr,
  input  logic [N-1:0]                   flushEntry,
  output logic [N-1:0]                   readyVector,
  output logic [N-1:0]                   validVector,
  output logic [IDXW:0]                  entryCount,
  output logic                           protocolError
);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [N-1:0] valid_q;
  logic [N-1:0] issued_q;
  logic [N-1:0] dep_q [N];
  logic [IDXW:0] count_q;
  logic          error_q;

  logic [N-1:0] valid_d;
  logic [N-1:0] issued_d;
  logic [N-1:0] dep_d [N];
  logic [IDXW:0] count_d;
  logic          error_d;

  // -------------------------------------------------------------------------
  // Unpack lane buses
  // -------------------------------------------------------------------------
  logic [IDXW-1:0] disp_ptr [DISPATCH_WIDTH];
  logic [N-1:0]    disp_dep [DISPATCH_WIDTH];
  logic [IDXW-1:0] sel_ptr  [WAKEUP_WIDTH];
  logic [IDXW-1:0] rel_ptr  [WAKEUP_WIDTH];
  logic [N-1:0]    wake_vec [WAKEUP_WIDTH];

  for (genvar d = 0; d < DISPATCH_WIDTH; d++) begin : g_disp_unpack
    assign disp_ptr[d] = dispatchPtr[d*IDXW +: IDXW];
    assign disp_dep[d] = dispatchDep[d*N +: N];
  end

  for (genvar k = 0; k < WAKEUP_WIDTH; k++) begin : g_lane_unpack
    assign sel_ptr[k]  = selectedPtr[k*IDXW +: IDXW];
    assign rel_ptr[k]  = releasePtr[k*IDXW +: IDXW];
    assign wake_vec[k] = wakeupVector[k*N +: N];
  end

  // -------------------------------------------------------------------------
  // Wake mask: union of all valid wakeup lanes. Clearing is an AND-NOT, so a
  // wakeup held across a stall clears nothing new.
  // -------------------------------------------------------------------------
  logic [N-1:0] wake_mask;

  always_comb begin
    wake_mask = '0;
    for (int k = 0; k < WAKEUP_WIDTH; k++) begin
      if (wakeup[k]) begin
        wake_mask = wake_mask | wake_vec[k];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Per-entry decode of dispatch / select / release strobes
  // -------------------------------------------------------------------------
  logic [N-1:0] disp_hit;
  logic [N-1:0] disp_row [N];
  logic [N-1:0] sel_hit;
  logic [N-1:0] rel_hit;

  always_comb begin
    disp_hit = '0;
    for (int i = 0; i < N; i++) begin
      disp_row[i] = '0;
    end
    // Walk lanes from highest to lowest so the lowest lane's write lands last
    // and wins when two lanes collide on one entry.
    for (int d = DISPATCH_WIDTH - 1; d >= 0; d--) begin
      if (dispatch[d]) begin
        disp_hit[disp_ptr[d]] = 1'b1;
        disp_row[disp_ptr[d]] = disp_dep[d];
      end
    end
  end

  always_comb begin
    sel_hit = '0;
    rel_hit = '0;
    for (int k = 0; k < WAKEUP_WIDTH; k++) begin
      if (selected[k]) begin
        sel_hit[sel_ptr[k]] = 1'b1;
      end
      if (releaseEntry[k]) begin
        rel_hit[rel_ptr[k]] = 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Ready vector
  // -------------------------------------------------------------------------
  logic [N-1:0] ready_out;

  always_comb begin
    ready_out = '0;
    for (int i = 0; i < N; i++) begin
`ifdef RSD_WAKEUP_READY_BYPASS_EN
      // Producers being woken right now no longer count as outstanding.
      ready_out[i] = valid_q[i] & ~issued_q[i] & ((dep_q[i] & ~wake_mask) == '0);
`else
      ready_out[i] = valid_q[i] & ~issued_q[i] & (dep_q[i] == '0);
`endif
    end
  end

  // -------------------------------------------------------------------------
  // Next-state. Later assignments override earlier ones, which gives the
  // same-entry priority dispatch > flush > release > select.
  // -------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < N; i++) begin
      valid_d[i]  = valid_q[i];
      issued_d[i] = issued_q[i] | sel_hit[i];
      dep_d[i]    = dep_q[i] & ~wake_mask;

      // Release of an entry that is not valid leaves it untouched.
      if (rel_hit[i] && valid_q[i]) begin
        valid_d[i]  = 1'b0;
        issued_d[i] = 1'b0;
        dep_d[i]    = '0;
      end

      // Flush clears only the row. Consumers of a flushed producer are
      // younger and are flushed together with it, so the column is left alone.
      if (flushEntry[i]) begin
        valid_d[i]  = 1'b0;
        issued_d[i] = 1'b0;
        dep_d[i]    = '0;
      end

      // A same-cycle wakeup is folded into the written row. An op never
      // waits on its own entry.
      if (disp_hit[i]) begin
        valid_d[i]  = 1'b1;
        issued_d[i] = 1'b0;
        dep_d[i]    = disp_row[i] & ~wake_mask;
        dep_d[i][i] = 1'b0;
      end
    end
  end

  // Occupancy of the next state. This is bounded by N by construction.
  always_comb begin
    count_d = '0;
    for (int i = 0; i < N; i++) begin
      count_d = count_d + {{IDXW{1'b0}}, valid_d[i]};
    end
  end

  // -------------------------------------------------------------------------
  // Protocol checks (sticky)
  // -------------------------------------------------------------------------
  always_comb begin
    error_d = error_q;
    for (int d = 0; d < DISPATCH_WIDTH; d++) begin
      // Dispatch onto a live entry is legal only if that entry is freed in
      // the same cycle.
      if (dispatch[d] && valid_q[disp_ptr[d]] &&
          !(flushEntry[disp_ptr[d]] || rel_hit[disp_ptr[d]])) begin
        error_d = 1'b1;
      end
      for (int e = 0; e < d; e++) begin
        if (dispatch[d] && dispatch[e] && (disp_ptr[d] == disp_ptr[e])) begin
          error_d = 1'b1;
        end
      end
    end
    for (int k = 0; k < WAKEUP_WIDTH; k++) begin
      if (selected[k] && !ready_out[sel_ptr[k]]) begin
        error_d = 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q  <= '0;
      issued_q <= '0;
      for (int i = 0; i < N; i++) begin
        dep_q[i] <= '0;
      end
      count_q  <= '0;
      error_q  <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      issued_q <= issued_d;
      for (int i = 0; i < N; i++) begin
        dep_q[i] <= dep_d[i];
      end
      count_q  <= count_d;
      error_q  <= error_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign readyVector   = ready_out;
  assign validVector   = valid_q;
  assign entryCount    = count_q;
  assign protocolError = error_q;

endmodule
